// File: rtl/serial_tx_pkg.sv
// ============================================================================
// serial_tx_pkg : shared types and constants for the serial transmitter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_tx_pkg;

  localparam int C_DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tx_shift_reg.sv
// ============================================================================
// tx_shift_reg : parallel-load left shift register, zero fill, clr > ld > shl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_shift_reg
  import serial_tx_pkg::*;
#(
  parameter int W = C_DEFAULT_W
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic         shl_i,
  input  logic [W-1:0] d_i,
  output logic         msb_o
);

  logic [W-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      sh_q <= '0;
    end else if (ld_i) begin
      sh_q <= d_i;
    end else if (shl_i) begin
      sh_q <= {sh_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = sh_q[W-1];

endmodule

`default_nettype wire

// File: rtl/serial_tx_ctrl.sv
// ============================================================================
// serial_tx_ctrl : MSB-first parallel-to-serial frame transmitter with abort.
// Optional trailing even-parity bit enabled by macro SERIAL_TX_PARITY_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx_ctrl
  import serial_tx_pkg::*;
#(
  parameter int W = C_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         d_valid,
  output logic         d_ready,
  input  logic         abort,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          sh_msb;
  logic          accept;
  logic          kill;
  logic          last_bit;
`ifdef SERIAL_TX_PARITY_EN
  logic          parity_q;
`endif

  assign d_ready  = (state_q == IDLE) && !abort;
  assign accept   = d_valid && d_ready;
  assign kill     = abort && (state_q != IDLE);
  assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(W - 1));

  tx_shift_reg #(
    .W (W)
  ) u_shreg (
    .clk   (clk),
    .clr_i (rst || kill),
    .ld_i  (accept),
    .shl_i (state_q == SHIFT),
    .d_i   (d),
    .msb_o (sh_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= SHIFT;
            cnt_q    <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^d;
`endif
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
              state_q <= PAR;
`else
              state_q <= IDLE;
              done_q  <= 1'b1;
`endif
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PAR: begin
          state_q <= IDLE;
          done_q  <= !abort;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Serial outputs are pure decodes of registered state, so they never glitch on inputs.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    case (state_q)
      SHIFT: begin
        sout       = sh_msb;
        sout_valid = 1'b1;
      end
`ifdef SERIAL_TX_PARITY_EN
      PAR: begin
        sout       = parity_q;
        sout_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_ctrl.sv
// ============================================================================
// tb_serial_tx_ctrl : scoreboard bench for serial_tx_ctrl at W=4
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_tx_ctrl;

  localparam int W = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d = '0;
  logic         d_valid = 1'b0;
  logic         abort = 1'b0;
  logic         d_ready, sout, sout_valid, busy, done;

  serial_tx_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .abort      (abort),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   c;
    logic b;
  } bit_t;

  bit_t bitq[$];
  int   doneq[$];
  int   cyc = 0;
  int   start = 0;
  int   busy_until = 0;
  bit   mon_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a frame accepted at edge n is busy over cycles [n, n+L).
  task automatic kill_next();
    int k;
    if (cyc >= start && cyc < busy_until) begin
      k = cyc + 1;
      busy_until = k;
      while (bitq.size() > 0 && bitq[$].c >= k) void'(bitq.pop_back());
      while (doneq.size() > 0 && doneq[$] >= k) void'(doneq.pop_back());
    end
  endtask

  task automatic send(input logic [W-1:0] w, input bit keep);
    bit   acc;
    int   n;
    bit_t e;
    d = w;
    d_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 4 * L + 4 && !acc; k++) begin
      acc = (cyc >= busy_until) && !abort && !rst;
      tick();
      if (acc) begin
        n = cyc;
        start = n;
        busy_until = n + L;
        for (int i = 0; i < W; i++) begin
          e.c = n + i;
          e.b = w[W-1-i];
          bitq.push_back(e);
        end
        if (L > W) begin
          e.c = n + W;
          e.b = ^w;
          bitq.push_back(e);
        end
        doneq.push_back(n + L);
      end
    end
    chk("accept_within_bound", {31'd0, acc}, 32'd1);
    if (keep) d = W'($urandom);
    else d_valid = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc <= busy_until) tick();
  endtask

  always @(negedge clk) begin
    logic ev, ed, eb;
    if (mon_en) begin
      eb = (cyc >= start) && (cyc < busy_until);
      ev = (bitq.size() > 0) && (bitq[0].c == cyc);
      ed = (doneq.size() > 0) && (doneq[0] == cyc);
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("d_ready", {31'd0, d_ready}, {31'd0, !eb && !abort});
      chk("sout_valid", {31'd0, sout_valid}, {31'd0, ev});
      chk("sout", {31'd0, sout}, {31'd0, ev ? bitq[0].b : 1'b0});
      chk("done", {31'd0, done}, {31'd0, ed});
      if (ev) void'(bitq.pop_front());
      if (ed) void'(doneq.pop_front());
    end
  end

  initial begin
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    send(4'b1010, 1'b0);
    wait_done();
    send(4'b1011, 1'b0);
    wait_done();

    // back-to-back with d_valid held high
    send(4'b1100, 1'b1);
    send(4'b0011, 1'b0);
    wait_done();

    // abort while idle blocks acceptance
    d = 4'b0101;
    d_valid = 1'b1;
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    send(4'b0101, 1'b0);
    wait_done();

    // abort on the second bit
    send(4'b1111, 1'b0);
    tick();
    abort = 1'b1;
    kill_next();
    tick();
    abort = 1'b0;
    tick();
    wait_done();

    // reset on the third bit, then a clean frame
    send(4'b1111, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    kill_next();
    tick();
    rst = 1'b0;
    tick();
    send(4'b0110, 1'b0);
    wait_done();

    for (int it = 0; it < 40; it++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) d_valid = 1'b0;
      repeat (gap) tick();
      send(W'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(0, L - 1)) tick();
        abort = 1'b1;
        kill_next();
        tick();
        abort = 1'b0;
      end
    end
    d_valid = 1'b0;
    wait_done();
    tick();

    chk("bits_drained", bitq.size(), 32'd0);
    chk("dones_drained", doneq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
